mfb_frame_lng_check: RTL and testbench
======================================

# mfb_frame_lng_check

Multi-region MFB frame-length meter and checker, inserted inline on an MFB stream, typically between a MAC RX and the first buffering stage. Passes the stream through one register stage. Annotates every region that carries an EOF with the length of the frame ending there, in items, saturated or wrapped per parameter. Raises undersize and oversize flags against configurable limits, and optionally keeps per-block frame statistics.

## Interface
Parameters:
- REGIONS, 1, number of MFB regions per word
- REGION_SIZE, 4, blocks per region (power of 2)
- BLOCK_SIZE, 8, items per block (power of 2)
- ITEM_WIDTH, 8, bits per item
- LNG_WIDTH, 16, width of reported length
- SATURATION, 0, 1 = clamp length at 2^LNG_WIDTH-1; 0 = wrap modulo 2^LNG_WIDTH
- FRAME_SIZE_MIN, 60, frames shorter than this (items) are flagged undersize
- FRAME_SIZE_MAX, 1526, frames longer than this are flagged oversize

Ports (RW = REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH; SP = log2(REGION_SIZE); EP = log2(REGION_SIZE*BLOCK_SIZE)):
- CLK  in  1  clock
- RESET_N  in  1  synchronous, active-low reset
- RX_DATA / RX_SOF_POS / RX_EOF_POS  in  RW / REGIONS*SP / REGIONS*EP  MFB data, SOF block position, EOF item position
- RX_SOF / RX_EOF  in  REGIONS each  per-region SOF/EOF
- RX_SRC_RDY  in  1;  RX_DST_RDY  out  1
- TX_DATA, TX_SOF_POS, TX_EOF_POS, TX_SOF, TX_EOF, TX_SRC_RDY  out  same widths  registered copy of RX
- TX_DST_RDY  in  1
- TX_FRAME_LNG  out  REGIONS*LNG_WIDTH  length of the frame ending in the region; valid where TX_EOF=1
- TX_LNG_UNDER / TX_LNG_OVER  out  REGIONS each  length < FRAME_SIZE_MIN / > FRAME_SIZE_MAX; valid where TX_EOF=1
- STAT_CLEAR  in  1  clears statistics counters
- STAT_FRAMES / STAT_UNDER / STAT_OVER  out  32 each  frame, undersize and oversize counters

## Operation
- Accept condition: RX_SRC_RDY & RX_DST_RDY. RX_DST_RDY = TX_DST_RDY | !TX_SRC_RDY.
- An internal accumulator ACC (LNG_WIDTH+1 bits) holds the in-progress frame length. Its extra bit is a sticky overflow marker (OVF).
- Per-region processing is in order, from region 0 upward, combinationally chained within one word:
  - SOF item index = SOF_POS*BLOCK_SIZE. EOF item index = EOF_POS.
  - EOF-before-SOF in the same region (EOF_POS < SOF item index, or the frame is open and EOF is present) closes the old frame first. Closed length = ACC + EOF_POS + 1.
  - A SOF with EOF_POS >= SOF item index in the same region (no open frame) is a single-region frame. Length = EOF_POS - SOF item + 1.
  - An open frame with no EOF adds REGION_SIZE*BLOCK_SIZE items. A SOF left open adds REGION_SIZE*BLOCK_SIZE - SOF item.
- Width rule: any sum ≥ 2^LNG_WIDTH sets OVF.
  - SATURATION=1: reported length = 2^LNG_WIDTH-1 when OVF.
  - SATURATION=0: reported length = low LNG_WIDTH bits.
- Flags are evaluated on the true length:
  - OVF forces OVER=1 and UNDER=0.
  - FRAME_SIZE_MAX ≥ 2^LNG_WIDTH is legal; comparison uses the LNG_WIDTH+1-bit value.
- ACC and OVF clear on every frame close.
- Malformed input (SOF while a frame is open, EOF with no frame open) is undefined. No recovery is required.
- Holding rule: the output register holds all TX_* while TX_SRC_RDY & !TX_DST_RDY. ACC updates only on accept.

## Timing
- Latency: 1 cycle from RX accept to TX presentation. Full throughput: one word per cycle when TX_DST_RDY=1.
- Reset (RESET_N=0 at a CLK edge):
  - TX_SRC_RDY=0; TX_SOF=TX_EOF=0; TX_FRAME_LNG=0; flags=0.
  - ACC=0, OVF=0, frame-open=0; all STAT_*=0.
  - TX_DATA/POS unspecified.
- Reset mid-frame discards the partial frame. The next frame must start with SOF.
- STAT_* update on the TX transfer cycle (TX_SRC_RDY & TX_DST_RDY) and are visible one cycle later.
  - Multiple EOFs per word add their count.
  - STAT_CLEAR in the same cycle as a transfer wins: counter becomes 0.
  - Counters saturate at 2^32-1.

## Configuration
- FRAME_LNG_CHECK_STATS_EN defined: statistics counters are built as described.
- Not defined: counters are not synthesised, STAT_* are constant 0, and STAT_CLEAR is ignored. Length and flag outputs are identical in both builds.

## Test plan
Defaults, except REGIONS=1, LNG_WIDTH=9, FRAME_SIZE_MAX=512; 32 items per word.
- Single-word frame, SOF_POS=0, EOF_POS=31 -> next cycle TX_FRAME_LNG=32, UNDER=1, OVER=0, STAT_FRAMES=1, STAT_UNDER=1.
- Three-word frame, SOF_POS=1 (item 8), EOF_POS=3 in word 3 -> length 24+32+4=60, UNDER=0, OVER=0.
- Region with EOF_POS=7 closing a 2-word frame started at item 0, plus SOF_POS=2 in the same region; next word EOF_POS=15 -> lengths 40 then 32 (16+16), both reported in order.
- 600-item frame -> SATURATION=1: length 511, OVER=1; SATURATION=0: length 88, OVER=1.
- TX_DST_RDY=0 for 5 cycles mid-frame -> TX_* stable, RX_DST_RDY=0 after the register fills, no word lost or duplicated, lengths unchanged versus a no-stall run.
- RESET_N=0 mid-frame, then a fresh 64-item frame -> TX_SRC_RDY=0 during reset, reported length 64, STAT_* restart from 0. Rebuild without FRAME_LNG_CHECK_STATS_EN -> STAT_* stay 0.

Source files
------------

// File: rtl/mfb_frame_lng_check_if.sv
`default_nettype none
// ============================================================================
// Module   : mfb_frame_lng_check_if
// Brief    : Multi-region MFB stream bundle (data, SOF/EOF and positions,
//            src/dst ready), with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface mfb_frame_lng_check_if #(
  parameter int REGIONS     = 1,
  parameter int REGION_SIZE = 4,
  parameter int BLOCK_SIZE  = 8,
  parameter int ITEM_WIDTH  = 8
);
  localparam int C_SP = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
  localparam int C_EP = $clog2(REGION_SIZE * BLOCK_SIZE);

  logic [REGIONS*REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] data;
  logic [REGIONS*C_SP-1:0]                              sof_pos;
  logic [REGIONS*C_EP-1:0]                              eof_pos;
  logic [REGIONS-1:0]                                   sof;
  logic [REGIONS-1:0]                                   eof;
  logic                                                 src_rdy;
  logic                                                 dst_rdy;

  modport master (output data, sof_pos, eof_pos, sof, eof, src_rdy, input  dst_rdy);
  modport slave  (input  data, sof_pos, eof_pos, sof, eof, src_rdy, output dst_rdy);
endinterface
`default_nettype wire

// File: rtl/mfb_frame_lng_check.sv
`default_nettype none
// ============================================================================
// Module   : mfb_frame_lng_check
// Brief    : Inline MFB frame-length meter; annotates EOF regions with the
//            frame length and undersize/oversize flags. Statistics counters
//            are built only when FRAME_LNG_CHECK_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mfb_frame_lng_check #(
  parameter int REGIONS        = 1,
  parameter int REGION_SIZE    = 4,
  parameter int BLOCK_SIZE     = 8,
  parameter int ITEM_WIDTH     = 8,
  parameter int LNG_WIDTH      = 16,
  parameter int SATURATION     = 0,
  parameter int FRAME_SIZE_MIN = 60,
  parameter int FRAME_SIZE_MAX = 1526
) (
  input  logic                         clk,
  input  logic                         reset_n,
  mfb_frame_lng_check_if.slave         rx,
  mfb_frame_lng_check_if.master        tx,
  output logic [REGIONS*LNG_WIDTH-1:0] tx_frame_lng,
  output logic [REGIONS-1:0]           tx_lng_under,
  output logic [REGIONS-1:0]           tx_lng_over,
  input  logic                         stat_clear,
  output logic [31:0]                  stat_frames,
  output logic [31:0]                  stat_under,
  output logic [31:0]                  stat_over
);
  localparam int C_SP = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
  localparam int C_EP = $clog2(REGION_SIZE * BLOCK_SIZE);
  localparam int C_BB = $clog2(BLOCK_SIZE);
  localparam int C_RW = REGIONS * REGION_SIZE * BLOCK_SIZE * ITEM_WIDTH;
  localparam logic [C_EP:0] C_WORD = (C_EP + 1)'(REGION_SIZE * BLOCK_SIZE);
  localparam logic [C_EP:0] C_ONE  = (C_EP + 1)'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OPEN = 1'b1} state_t;

  state_t                         r_state, w_state_next;
  logic [LNG_WIDTH:0]             r_acc, w_acc_next;   // MSB is sticky overflow
  logic                           r_src_rdy;
  logic [C_RW-1:0]                r_data;
  logic [REGIONS*C_SP-1:0]        r_sof_pos;
  logic [REGIONS*C_EP-1:0]        r_eof_pos;
  logic [REGIONS-1:0]             r_sof, r_eof, r_under, r_over;
  logic [REGIONS*LNG_WIDTH-1:0]   r_lng;
  logic [REGIONS*LNG_WIDTH-1:0]   w_lng;
  logic [REGIONS-1:0]             w_under, w_over;
  logic                           w_dst_rdy, w_accept;

  function automatic logic [LNG_WIDTH:0] acc_add(input logic [LNG_WIDTH:0] acc,
                                                 input logic [C_EP:0]      val);
    logic [LNG_WIDTH+1:0] sum;
    sum = {2'b00, acc[LNG_WIDTH-1:0]} + {{(LNG_WIDTH + 1 - C_EP){1'b0}}, val};
    return {acc[LNG_WIDTH] | sum[LNG_WIDTH] | sum[LNG_WIDTH+1], sum[LNG_WIDTH-1:0]};
  endfunction

  function automatic logic [LNG_WIDTH-1:0] report(input logic [LNG_WIDTH:0] v);
    if (SATURATION != 0 && v[LNG_WIDTH]) return '1;
    return v[LNG_WIDTH-1:0];
  endfunction

  assign w_dst_rdy  = tx.dst_rdy | ~r_src_rdy;
  assign w_accept   = rx.src_rdy & w_dst_rdy;
  assign rx.dst_rdy = w_dst_rdy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
    end else if (w_accept) begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
    end
  end

  // Regions are walked in order so a word may close one frame and open the next.
  always_comb begin
    logic               w_open, w_sof, w_eof, w_close_old, w_single, w_open_new;
    logic [C_EP-1:0]    w_sof_item, w_eof_item;
    logic [LNG_WIDTH:0] w_acc, w_fin;
    w_open      = (r_state == ST_OPEN);
    w_acc       = r_acc;
    w_sof       = 1'b0;
    w_eof       = 1'b0;
    w_close_old = 1'b0;
    w_single    = 1'b0;
    w_open_new  = 1'b0;
    w_sof_item  = '0;
    w_eof_item  = '0;
    w_fin       = '0;
    w_lng       = '0;
    w_under     = '0;
    w_over      = '0;
    for (int r = 0; r < REGIONS; r++) begin
      w_sof       = rx.sof[r];
      w_eof       = rx.eof[r];
      w_sof_item  = C_EP'(rx.sof_pos[r*C_SP +: C_SP]) << C_BB;
      w_eof_item  = rx.eof_pos[r*C_EP +: C_EP];
      w_close_old = w_eof & (w_open | (w_sof & (w_eof_item < w_sof_item)));
      w_single    = w_eof & w_sof & ~w_close_old;
      w_open_new  = w_sof & ~w_single;
      w_fin       = '0;
      if (w_close_old) begin
        w_fin  = acc_add(w_acc, {1'b0, w_eof_item} + C_ONE);
        w_acc  = '0;
        w_open = 1'b0;
      end else if (w_open) begin
        w_acc = acc_add(w_acc, C_WORD);
      end
      if (w_single) begin
        w_fin = acc_add('0, {1'b0, w_eof_item - w_sof_item} + C_ONE);
      end
      if (w_open_new) begin
        w_acc  = acc_add('0, C_WORD - {1'b0, w_sof_item});
        w_open = 1'b1;
      end
      if (w_eof) begin
        w_lng[r*LNG_WIDTH +: LNG_WIDTH] = report(w_fin);
        w_under[r] = ~w_fin[LNG_WIDTH] &
                     (64'(w_fin[LNG_WIDTH-1:0]) < 64'(FRAME_SIZE_MIN));
        w_over[r]  = w_fin[LNG_WIDTH] |
                     (64'(w_fin[LNG_WIDTH-1:0]) > 64'(FRAME_SIZE_MAX));
      end
    end
    w_state_next = w_open ? ST_OPEN : ST_IDLE;
    w_acc_next   = w_acc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src_rdy <= 1'b0;
      r_data    <= '0;
      r_sof_pos <= '0;
      r_eof_pos <= '0;
      r_sof     <= '0;
      r_eof     <= '0;
      r_lng     <= '0;
      r_under   <= '0;
      r_over    <= '0;
    end else if (w_dst_rdy) begin
      r_src_rdy <= rx.src_rdy;
      r_data    <= rx.data;
      r_sof_pos <= rx.sof_pos;
      r_eof_pos <= rx.eof_pos;
      r_sof     <= rx.sof & {REGIONS{rx.src_rdy}};
      r_eof     <= rx.eof & {REGIONS{rx.src_rdy}};
      r_lng     <= w_lng;
      r_under   <= w_under;
      r_over    <= w_over;
    end
  end

  assign tx.src_rdy     = r_src_rdy;
  assign tx.data        = r_data;
  assign tx.sof_pos     = r_sof_pos;
  assign tx.eof_pos     = r_eof_pos;
  assign tx.sof         = r_sof;
  assign tx.eof         = r_eof;
  assign tx_frame_lng   = r_lng;
  assign tx_lng_under   = r_under;
  assign tx_lng_over    = r_over;

`ifdef FRAME_LNG_CHECK_STATS_EN
  logic [31:0] r_stat_frames, r_stat_under, r_stat_over;
  logic        w_xfer;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [REGIONS-1:0] hits);
    logic [32:0] sum;
    sum = {1'b0, cnt} + 33'($countones(hits));
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  assign w_xfer = r_src_rdy & tx.dst_rdy;

  always_ff @(posedge clk) begin
    if (!reset_n || stat_clear) begin
      r_stat_frames <= '0;
      r_stat_under  <= '0;
      r_stat_over   <= '0;
    end else if (w_xfer) begin
      r_stat_frames <= sat_inc(r_stat_frames, r_eof);
      r_stat_under  <= sat_inc(r_stat_under,  r_eof & r_under);
      r_stat_over   <= sat_inc(r_stat_over,   r_eof & r_over);
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_under  = r_stat_under;
  assign stat_over   = r_stat_over;
`else
  logic w_unused_stat_clear;
  assign w_unused_stat_clear = stat_clear;
  assign stat_frames = '0;
  assign stat_under  = '0;
  assign stat_over   = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mfb_frame_lng_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfb_frame_lng_check
// Brief    : Bench for mfb_frame_lng_check; a saturating and a wrapping DUT
//            share one stimulus stream built from a list of frame lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfb_frame_lng_check;
  localparam int LW = 9;
`ifdef FRAME_LNG_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stat_clear = 1'b0;
  always #5 clk = ~clk;

  mfb_frame_lng_check_if #(.REGIONS(1)) rx_a (), tx_a (), rx_b (), tx_b ();

  logic [LW-1:0] lng_a, lng_b;
  logic          under_a, over_a, under_b, over_b;
  logic [31:0]   sf_a, su_a, so_a, sf_b, su_b, so_b;

  assign rx_b.data    = rx_a.data;
  assign rx_b.sof_pos = rx_a.sof_pos;
  assign rx_b.eof_pos = rx_a.eof_pos;
  assign rx_b.sof     = rx_a.sof;
  assign rx_b.eof     = rx_a.eof;
  assign rx_b.src_rdy = rx_a.src_rdy;
  assign tx_b.dst_rdy = tx_a.dst_rdy;

  mfb_frame_lng_check #(.REGIONS(1), .LNG_WIDTH(LW), .SATURATION(1), .FRAME_SIZE_MAX(512)) dut_a (
    .clk(clk), .reset_n(reset_n), .rx(rx_a), .tx(tx_a),
    .tx_frame_lng(lng_a), .tx_lng_under(under_a), .tx_lng_over(over_a),
    .stat_clear(stat_clear), .stat_frames(sf_a), .stat_under(su_a), .stat_over(so_a));

  mfb_frame_lng_check #(.REGIONS(1), .LNG_WIDTH(LW), .SATURATION(0), .FRAME_SIZE_MAX(512)) dut_b (
    .clk(clk), .reset_n(reset_n), .rx(rx_b), .tx(tx_b),
    .tx_frame_lng(lng_b), .tx_lng_under(under_b), .tx_lng_over(over_b),
    .stat_clear(stat_clear), .stat_frames(sf_b), .stat_under(su_b), .stat_over(so_b));

  int n_tests = 0;
  int n_fail  = 0;

  // Frame list for the next stream and the word image derived from it
  int           f_len[$];
  int           f_gap[$];
  logic [255:0] w_data[$];
  logic [1:0]   w_sp[$];
  logic [4:0]   w_ep[$];
  logic         w_sof[$];
  logic         w_eof[$];
  int           exp_len[$];
  int           m_frames = 0, m_under = 0, m_over = 0;

  function automatic int rep_len(input int len, input bit sat);
    if (len >= 512) return sat ? 511 : len % 512;
    return len;
  endfunction
  function automatic bit exp_under(input int len);
    return (len < 512) && (len < 60);
  endfunction
  function automatic bit exp_over(input int len);
    return len >= 512;
  endfunction

  // Lay frames onto a flat item stream: SOF block-aligned, at most one SOF
  // and one EOF per 32-item word, SOF after EOF when they share a word.
  task automatic build();
    int cur, last_sof, last_eof, st, en, sw, ew;
    int st_q[$], en_q[$];
    cur = 0; last_sof = -1; last_eof = -1;
    w_data.delete(); w_sp.delete(); w_ep.delete(); w_sof.delete(); w_eof.delete();
    exp_len.delete();
    for (int i = 0; i < f_len.size(); i++) begin
      st = ((cur + f_gap[i] + 7) / 8) * 8; sw = st / 32;
      en = st + f_len[i] - 1; ew = en / 32;
      if (sw == last_sof || (sw == last_eof && ew == sw)) begin
        sw = sw + 1; st = sw * 32; en = st + f_len[i] - 1; ew = en / 32;
      end
      st_q.push_back(st); en_q.push_back(en); exp_len.push_back(f_len[i]);
      last_sof = sw; last_eof = ew; cur = en + 1;
    end
    for (int w = 0; w < (cur + 31) / 32; w++) begin
      w_data.push_back({$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()});
      w_sp.push_back(2'd0); w_ep.push_back(5'd0);
      w_sof.push_back(1'b0); w_eof.push_back(1'b0);
    end
    for (int i = 0; i < st_q.size(); i++) begin
      w_sof[st_q[i] / 32] = 1'b1;
      w_sp[st_q[i] / 32]  = 2'((st_q[i] % 32) / 8);
      w_eof[en_q[i] / 32] = 1'b1;
      w_ep[en_q[i] / 32]  = 5'(en_q[i] % 32);
    end
  endtask

  task automatic drive_word(input int idx, input bit valid);
    rx_a.src_rdy = valid;
    rx_a.data    = w_data[idx];
    rx_a.sof_pos = w_sp[idx];
    rx_a.eof_pos = w_ep[idx];
    rx_a.sof     = w_sof[idx];
    rx_a.eof     = w_eof[idx];
  endtask

  // mode 0: no stalls; 1: random idles and back-pressure; 2: 5-cycle stall
  task automatic run_stream(input int mode, input string name);
    int idx, cyc, k, len;
    int sent[$];
    bit held;
    logic [255:0]  p_data;
    logic          p_sof, p_eof;
    logic [LW-1:0] p_lng;
    logic [LW-1:0] e_lng;
    idx = 0; cyc = 0; held = 1'b0;
    p_data = '0; p_sof = 1'b0; p_eof = 1'b0; p_lng = '0;
    while ((idx < w_data.size() || sent.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      if (idx < w_data.size()) drive_word(idx, (mode != 1) || ($urandom_range(3) != 0));
      else begin
        rx_a.src_rdy = 1'b0; rx_a.sof = 1'b0; rx_a.eof = 1'b0;
      end
      if (mode == 2) tx_a.dst_rdy = !(cyc >= 4 && cyc < 9);
      else if (mode == 1) tx_a.dst_rdy = ($urandom_range(3) != 0);
      else tx_a.dst_rdy = 1'b1;
      #1;
      n_tests++;
      if (tx_b.src_rdy !== tx_a.src_rdy) begin
        n_fail++;
        $display("FAIL %s src_rdy_pair: got %b expected %b", name, tx_b.src_rdy, tx_a.src_rdy);
      end
      if (held) begin
        n_tests++;
        if (tx_a.data !== p_data || tx_a.sof !== p_sof || tx_a.eof !== p_eof || lng_a !== p_lng) begin
          n_fail++;
          $display("FAIL %s hold: got sof=%b eof=%b lng=%0d expected sof=%b eof=%b lng=%0d",
                   name, tx_a.sof, tx_a.eof, lng_a, p_sof, p_eof, p_lng);
        end
      end
      if (tx_a.src_rdy && !tx_a.dst_rdy) begin
        n_tests++;
        if (rx_a.dst_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s rx_dst_rdy_full: got %b expected 0", name, rx_a.dst_rdy);
        end
      end
      held = tx_a.src_rdy & ~tx_a.dst_rdy;
      p_data = tx_a.data; p_sof = tx_a.sof; p_eof = tx_a.eof; p_lng = lng_a;
      if (tx_a.src_rdy && tx_a.dst_rdy) begin
        n_tests++;
        if (sent.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_word: got a transfer expected none", name);
        end else begin
          k = sent.pop_front();
          if (tx_a.data !== w_data[k] || tx_a.sof !== w_sof[k] || tx_a.eof !== w_eof[k] ||
              (w_sof[k] && tx_a.sof_pos !== w_sp[k]) || (w_eof[k] && tx_a.eof_pos !== w_ep[k])) begin
            n_fail++;
            $display("FAIL %s word%0d: got sof=%b/%0d eof=%b/%0d expected sof=%b/%0d eof=%b/%0d",
                     name, k, tx_a.sof, tx_a.sof_pos, tx_a.eof, tx_a.eof_pos,
                     w_sof[k], w_sp[k], w_eof[k], w_ep[k]);
          end
          if (w_eof[k] && exp_len.size() > 0) begin
            len = exp_len.pop_front();
            e_lng = LW'(rep_len(len, 1'b1));
            n_tests++;
            if (lng_a !== e_lng || under_a !== exp_under(len) || over_a !== exp_over(len)) begin
              n_fail++;
              $display("FAIL %s sat_len%0d: got lng=%0d u=%b o=%b expected lng=%0d u=%b o=%b",
                       name, len, lng_a, under_a, over_a, e_lng, exp_under(len), exp_over(len));
            end
            e_lng = LW'(rep_len(len, 1'b0));
            n_tests++;
            if (lng_b !== e_lng || under_b !== exp_under(len) || over_b !== exp_over(len)) begin
              n_fail++;
              $display("FAIL %s wrap_len%0d: got lng=%0d u=%b o=%b expected lng=%0d u=%b o=%b",
                       name, len, lng_b, under_b, over_b, e_lng, exp_under(len), exp_over(len));
            end
            m_frames++;
            m_under += int'(exp_under(len));
            m_over  += int'(exp_over(len));
          end
        end
      end
      if (rx_a.src_rdy && rx_a.dst_rdy) begin
        sent.push_back(idx);
        idx++;
      end
      cyc++;
    end
    n_tests++;
    if (cyc >= 3000 || exp_len.size() != 0) begin
      n_fail++;
      $display("FAIL %s completion: got %0d frames pending after %0d cycles expected 0",
               name, exp_len.size(), cyc);
    end
    @(negedge clk);
    rx_a.src_rdy = 1'b0; rx_a.sof = 1'b0; rx_a.eof = 1'b0; tx_a.dst_rdy = 1'b1;
  endtask

  task automatic check_stats(input string name);
    int ef, eu, eo;
    repeat (2) @(negedge clk);
    #1;
    ef = STATS ? m_frames : 0; eu = STATS ? m_under : 0; eo = STATS ? m_over : 0;
    n_tests++;
    if (sf_a !== 32'(ef)) begin n_fail++; $display("FAIL %s stat_frames: got %0d expected %0d", name, sf_a, ef); end
    n_tests++;
    if (su_a !== 32'(eu)) begin n_fail++; $display("FAIL %s stat_under: got %0d expected %0d", name, su_a, eu); end
    n_tests++;
    if (so_a !== 32'(eo)) begin n_fail++; $display("FAIL %s stat_over: got %0d expected %0d", name, so_a, eo); end
    n_tests++;
    if (sf_b !== 32'(ef) || su_b !== 32'(eu) || so_b !== 32'(eo)) begin
      n_fail++;
      $display("FAIL %s stat_b: got %0d/%0d/%0d expected %0d/%0d/%0d", name, sf_b, su_b, so_b, ef, eu, eo);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (tx_a.src_rdy !== 1'b0 || tx_a.sof !== 1'b0 || tx_a.eof !== 1'b0 || lng_a !== '0 ||
        under_a !== 1'b0 || over_a !== 1'b0 || tx_b.src_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got src=%b sof=%b eof=%b lng=%0d u=%b o=%b expected all 0",
               tx_a.src_rdy, tx_a.sof, tx_a.eof, lng_a, under_a, over_a);
    end
    n_tests++;
    if (rx_a.dst_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_dst_rdy: got %b expected 1", rx_a.dst_rdy);
    end
    n_tests++;
    if (sf_a !== 32'd0 || su_a !== 32'd0 || so_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", sf_a, su_a, so_a);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_word();
    f_len = '{32}; f_gap = '{0}; build();
    run_stream(0, "single_word");
    check_stats("single_word");
  endtask

  task automatic test_three_word();
    f_len = '{60}; f_gap = '{8}; build();
    run_stream(0, "three_word");
  endtask

  task automatic test_eof_sof_same_region();
    f_len = '{40, 32}; f_gap = '{0, 8}; build();
    run_stream(0, "eof_sof_region");
  endtask

  task automatic test_oversize();
    f_len = '{600}; f_gap = '{0}; build();
    run_stream(0, "oversize600");
  endtask

  task automatic test_boundaries();
    f_len = '{59, 60, 511, 512, 513, 1}; f_gap = '{0, 0, 0, 0, 0, 0}; build();
    run_stream(0, "boundaries");
    check_stats("boundaries");
  endtask

  task automatic test_stall();
    f_len = '{100, 45}; f_gap = '{0, 0}; build();
    run_stream(2, "stall5");
  endtask

  task automatic test_back_to_back_random();
    f_len.delete(); f_gap.delete();
    for (int i = 0; i < 14; i++) begin
      f_len.push_back(int'($urandom_range(700, 1)));
      f_gap.push_back(int'($urandom_range(40, 0)));
    end
    build();
    run_stream(1, "random");
    check_stats("random");
  endtask

  task automatic test_stat_clear();
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    m_frames = 0; m_under = 0; m_over = 0;
    check_stats("stat_clear");
  endtask

  task automatic test_reset_midframe();
    f_len = '{100}; f_gap = '{0}; build();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive_word(c, 1'b1);
      tx_a.dst_rdy = 1'b1;
    end
    @(negedge clk);
    rx_a.src_rdy = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (tx_a.src_rdy !== 1'b0 || tx_b.src_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_src_rdy: got %b/%b expected 0/0", tx_a.src_rdy, tx_b.src_rdy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_frames = 0; m_under = 0; m_over = 0;
    f_len = '{64}; f_gap = '{0}; build();
    run_stream(0, "fresh64");
    check_stats("fresh64");
  endtask

  initial begin
    rx_a.src_rdy = 1'b0; rx_a.data = '0; rx_a.sof_pos = '0; rx_a.eof_pos = '0;
    rx_a.sof = 1'b0; rx_a.eof = 1'b0; tx_a.dst_rdy = 1'b1;
    test_reset();
    test_single_word();
    test_three_word();
    test_eof_sof_same_region();
    test_oversize();
    test_boundaries();
    test_stall();
    test_back_to_back_random();
    test_stat_clear();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
